// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared constants and encodings for the ROM arbiter.
// Holds ROM geometry, burst length, FSM state and read-owner tag encodings.
// Imported by rom_arbiter and rom_arb_burst.
package rom_arbiter_pkg;

  localparam int ROM_ADDR_W  = 11;
  localparam int ROM_DEPTH   = 1 << ROM_ADDR_W;
  localparam int WORD_DATA_W = 32;
  localparam int BURST_LEN   = 4;
  localparam int BEAT_W      = $clog2(BURST_LEN);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Owner tag of an issued ROM access; decides which port sees the read data.
  typedef enum logic {
    OWN_BUS = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_arb_burst.sv
// rom_arb_burst: beat counter and critical-word-first wrap address generator.
// Ports: clk/reset; load_i captures the first-beat address (beat 0 is issued
//   by the parent), adv_i steps one beat; addr_o is the current beat address,
//   last_o flags the final beat of the burst.
module rom_arb_burst
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] low_sum;

  always_comb begin
    beat_d = beat_q;
    base_d = base_q;
    if (load_i) begin
      // Beat 0 goes out in the load cycle, so the next beat issued is 1.
      beat_d = BEAT_W'(1);
      base_d = addr_i;
    end else if (adv_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // Low bits wrap modulo the burst length; upper bits stay fixed.
  assign low_sum = base_q[BEAT_W-1:0] + beat_q;
  assign addr_o  = {base_q[ADDR_W-1:BEAT_W], low_sum};
  assign last_o  = (beat_q == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
      base_q <= '0;
    end else begin
      beat_q <= beat_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port read arbiter in front of a single-port synchronous ROM.
// Grant and rom_addr in cycle N, rvalid/rdata one cycle later; a fetch burst
//   blocks all grants for its remaining three beats.
// Ports: clk/reset; if_* fetch port (single or 4-beat wrap burst); bus_* bus
//   port (single reads); rom_addr/rom_douta to the ROM.
// Config macro ROM_ARB_RR_EN: round-robin on simultaneous requests; undefined
//   gives fixed priority to the fetch port.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              if_burst,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_last,
  input  logic              bus_req,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              bus_gnt,
  output logic              bus_rvalid,
  output logic [DATA_W-1:0] bus_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_douta
);

  arb_state_e        state_q, state_d;
  logic              rvalid_q, rvalid_d;
  owner_e            owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef ROM_ARB_RR_EN
  owner_e            rr_q, rr_d;     // port granted most recently
`endif

  logic              if_win, bus_win;
  logic              in_burst, burst_start, burst_last, issue;
  logic [ADDR_W-1:0] burst_addr, issue_addr;

  // Grants are gated by reset so nothing is granted while reset is held.
  assign in_burst = reset && (state_q == ST_BURST);

  always_comb begin
    if_win  = 1'b0;
    bus_win = 1'b0;
    if (reset && (state_q == ST_IDLE)) begin
`ifdef ROM_ARB_RR_EN
      if (if_req && bus_req) begin
        if_win  = (rr_q == OWN_BUS);
        bus_win = (rr_q == OWN_IF);
      end else begin
        if_win  = if_req;
        bus_win = bus_req;
      end
`else
      if_win  = if_req;
      bus_win = bus_req && !if_req;
`endif
    end
  end

  assign burst_start = if_win && if_burst;
  assign issue       = if_win || bus_win || in_burst;
  assign if_gnt      = if_win;
  assign bus_gnt     = bus_win;

  always_comb begin
    issue_addr = burst_addr;
    if (if_win) begin
      issue_addr = if_addr;
    end else if (bus_win) begin
      issue_addr = bus_addr;
    end
  end

  // Idle cycles keep presenting the last issued address.
  assign rom_addr = issue ? issue_addr : addr_q;

  rom_arb_burst #(
    .ADDR_W (ADDR_W)
  ) u_burst (
    .clk    (clk),
    .reset  (reset),
    .load_i (burst_start),
    .adv_i  (in_burst),
    .addr_i (if_addr),
    .addr_o (burst_addr),
    .last_o (burst_last)
  );

  always_comb begin
    state_d  = state_q;
    rvalid_d = issue;
    owner_d  = owner_q;
    last_d   = 1'b0;
    addr_d   = rom_addr;
`ifdef ROM_ARB_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      ST_IDLE:  if (burst_start) state_d = ST_BURST;
      ST_BURST: if (burst_last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (if_win) begin
      owner_d = OWN_IF;
      last_d  = !if_burst;
`ifdef ROM_ARB_RR_EN
      rr_d    = OWN_IF;
`endif
    end else if (bus_win) begin
      owner_d = OWN_BUS;
      last_d  = 1'b1;
`ifdef ROM_ARB_RR_EN
      rr_d    = OWN_BUS;
`endif
    end else if (in_burst) begin
      owner_d = OWN_IF;
      last_d  = burst_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rvalid_q <= 1'b0;
      owner_q  <= OWN_BUS;
      last_q   <= 1'b0;
      addr_q   <= '0;
`ifdef ROM_ARB_RR_EN
      rr_q     <= OWN_BUS;
`endif
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
`ifdef ROM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Read data is steered by the owner tag and forced to zero when not valid.
  assign if_rvalid  = rvalid_q && (owner_q == OWN_IF);
  assign bus_rvalid = rvalid_q && (owner_q == OWN_BUS);
  assign if_rdata   = if_rvalid  ? rom_douta : '0;
  assign bus_rdata  = bus_rvalid ? rom_douta : '0;
  assign if_last    = if_rvalid && last_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter.
// Directed vector table, hand-written burst/reset/contention sequences, then
// random traffic checked against a transaction-level reference model.
module tb_rom_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
`ifdef ROM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, if_burst = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid, if_last;
  logic [DW-1:0] if_rdata;
  logic          bus_req = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic          bus_gnt, bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_douta = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_burst(if_burst), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_last(if_last),
    .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rom_addr(rom_addr), .rom_douta(rom_douta)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {a, 21'h0} ^ {21'h0, a};
  endfunction

  // Synchronous ROM: one cycle of read latency.
  always @(posedge clk) rom_douta <= mem_val(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_gnt"},     64'(if_gnt),     64'd0);
    check({tag, " bus_gnt"},    64'(bus_gnt),    64'd0);
    check({tag, " if_rvalid"},  64'(if_rvalid),  64'd0);
    check({tag, " bus_rvalid"}, 64'(bus_rvalid), 64'd0);
    check({tag, " if_last"},    64'(if_last),    64'd0);
    check({tag, " if_rdata"},   64'(if_rdata),   64'd0);
    check({tag, " bus_rdata"},  64'(bus_rdata),  64'd0);
    check({tag, " rom_addr"},   64'(rom_addr),   64'd0);
  endtask

  typedef struct {
    logic          ir;
    logic          ib;
    logic [AW-1:0] ia;
    logic          br;
    logic [AW-1:0] ba;
    logic          eg_if;
    logic          eg_bus;
    logic [AW-1:0] e_addr;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t          tbl[7];
    logic [AW-1:0] wexp[4];
    logic          e_ifg;
    // reference model state for the random phase
    logic [AW-1:0] burst_q[$];
    logic          pend_v, pend_if, pend_last, rr_last_if;
    logic [AW-1:0] pend_addr, last_addr;
    logic          ti_req, ti_burst, tb_req;
    logic [AW-1:0] ti_addr, tb_addr;

    // ---------------- reset state (requests held high during reset) -------
    if_req = 1'b1; if_addr = 11'h055; bus_req = 1'b1; bus_addr = 11'h0AA;
    #12;
    check_all_zero("reset");
    if_req = 1'b0; bus_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();

    // ---------------- directed vector table -------------------------------
    //          ir    ib    ia       br    ba       g_if  g_bus addr
    tbl[0] = '{1'b1, 1'b0, 11'h010, 1'b0, 11'h000, 1'b1, 1'b0, 11'h010};
    tbl[1] = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h123, 1'b0, 1'b1, 11'h123};
    tbl[2] = '{1'b1, 1'b0, 11'h055, 1'b1, 11'h2AA, 1'b1, 1'b0, 11'h055};
    tbl[3] = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 11'h055};
    tbl[4] = '{1'b1, 1'b0, 11'h7FF, 1'b0, 11'h000, 1'b1, 1'b0, 11'h7FF};
    tbl[5] = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h000, 1'b0, 1'b1, 11'h000};
    tbl[6] = '{1'b1, 1'b0, 11'h3C3, 1'b1, 11'h111, 1'b1, 1'b0, 11'h3C3};
    for (int i = 0; i < 7; i++) begin
      if_req = tbl[i].ir; if_burst = tbl[i].ib; if_addr = tbl[i].ia;
      bus_req = tbl[i].br; bus_addr = tbl[i].ba;
      @(negedge clk);
      check($sformatf("vec%0d if_gnt", i),   64'(if_gnt),   64'(tbl[i].eg_if));
      check($sformatf("vec%0d bus_gnt", i),  64'(bus_gnt),  64'(tbl[i].eg_bus));
      check($sformatf("vec%0d rom_addr", i), 64'(rom_addr), 64'(tbl[i].e_addr));
      step();
      if_req = 1'b0; bus_req = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d if_rvalid", i),  64'(if_rvalid),  64'(tbl[i].eg_if));
      check($sformatf("vec%0d bus_rvalid", i), 64'(bus_rvalid), 64'(tbl[i].eg_bus));
      check($sformatf("vec%0d if_last", i),    64'(if_last),    64'(tbl[i].eg_if));
      check($sformatf("vec%0d if_rdata", i),   64'(if_rdata),
            tbl[i].eg_if ? 64'(mem_val(tbl[i].e_addr)) : 64'd0);
      check($sformatf("vec%0d bus_rdata", i),  64'(bus_rdata),
            tbl[i].eg_bus ? 64'(mem_val(tbl[i].e_addr)) : 64'd0);
      step();
    end

    // ---------------- wrap burst at 0x006 with bus request at N+1 ---------
    wexp[0] = 11'h006; wexp[1] = 11'h007; wexp[2] = 11'h004; wexp[3] = 11'h005;
    if_req = 1'b1; if_burst = 1'b1; if_addr = 11'h006;
    @(negedge clk);
    check("burst N if_gnt",   64'(if_gnt),   64'd1);
    check("burst N rom_addr", 64'(rom_addr), 64'(wexp[0]));
    step();
    if_req = 1'b0; if_burst = 1'b0;
    bus_req = 1'b1; bus_addr = 11'h321;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("burst N+%0d rom_addr", k), 64'(rom_addr), 64'(wexp[k]));
      check($sformatf("burst N+%0d bus_gnt", k),  64'(bus_gnt),  64'd0);
      check($sformatf("burst N+%0d if_gnt", k),   64'(if_gnt),   64'd0);
      check($sformatf("burst N+%0d if_rvalid", k), 64'(if_rvalid), 64'd1);
      check($sformatf("burst N+%0d if_rdata", k), 64'(if_rdata), 64'(mem_val(wexp[k-1])));
      check($sformatf("burst N+%0d if_last", k),  64'(if_last),  64'd0);
      step();
    end
    @(negedge clk);
    check("burst N+4 bus_gnt",   64'(bus_gnt),   64'd1);
    check("burst N+4 rom_addr",  64'(rom_addr),  64'h321);
    check("burst N+4 if_rvalid", 64'(if_rvalid), 64'd1);
    check("burst N+4 if_rdata",  64'(if_rdata),  64'(mem_val(wexp[3])));
    check("burst N+4 if_last",   64'(if_last),   64'd1);
    step();
    bus_req = 1'b0;
    @(negedge clk);
    check("burst N+5 bus_rvalid", 64'(bus_rvalid), 64'd1);
    check("burst N+5 bus_rdata",  64'(bus_rdata),  64'(mem_val(11'h321)));
    check("burst N+5 if_rvalid",  64'(if_rvalid),  64'd0);
    step();

    // ---------------- reset in the middle of a burst ----------------------
    if_req = 1'b1; if_burst = 1'b1; if_addr = 11'h0C9;
    @(negedge clk);
    check("rstburst if_gnt", 64'(if_gnt), 64'd1);
    step();
    if_req = 1'b0; if_burst = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_all_zero("rstburst");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("postrst%0d if_rvalid", k),  64'(if_rvalid),  64'd0);
      check($sformatf("postrst%0d bus_rvalid", k), 64'(bus_rvalid), 64'd0);
      check($sformatf("postrst%0d rom_addr", k),   64'(rom_addr),   64'd0);
    end
    step();

    // ---------------- simultaneous single requests x4 ---------------------
    if_req = 1'b1; if_addr = 11'h200; bus_req = 1'b1; bus_addr = 11'h300;
    for (int k = 0; k < 4; k++) begin
      e_ifg = RR_MODE ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      check($sformatf("sim%0d if_gnt", k),   64'(if_gnt),   64'(e_ifg));
      check($sformatf("sim%0d bus_gnt", k),  64'(bus_gnt),  64'(!e_ifg));
      check($sformatf("sim%0d rom_addr", k), 64'(rom_addr), 64'(e_ifg ? if_addr : bus_addr));
      step();
      if (e_ifg) if_addr = if_addr + 11'd1;
      else       bus_addr = bus_addr + 11'd1;
    end
    if_req = 1'b0;
    @(negedge clk);
    check("sim release bus_gnt", 64'(bus_gnt), 64'd1);
    step();
    bus_req = 1'b0;
    step();

    // ---------------- back-to-back bus reads 0x100..0x103 -----------------
    bus_req = 1'b1; bus_addr = 11'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check($sformatf("b2b%0d bus_gnt", k),  64'(bus_gnt),  64'd1);
        check($sformatf("b2b%0d rom_addr", k), 64'(rom_addr), 64'(11'h100 + 11'(k)));
      end
      if (k > 0) begin
        check($sformatf("b2b%0d bus_rvalid", k), 64'(bus_rvalid), 64'd1);
        check($sformatf("b2b%0d bus_rdata", k),  64'(bus_rdata),
              64'(mem_val(11'h100 + 11'(k - 1))));
      end
      step();
      if (k < 3) bus_addr = bus_addr + 11'd1;
      else       bus_req = 1'b0;
    end

    // ---------------- random traffic vs reference model -------------------
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    pend_v = 1'b0; pend_if = 1'b0; pend_last = 1'b0; pend_addr = '0;
    last_addr = '0; rr_last_if = 1'b0;
    ti_req = 1'b0; ti_burst = 1'b0; ti_addr = '0; tb_req = 1'b0; tb_addr = '0;
    for (int c = 0; c < 400; c++) begin
      logic          g_if, g_bus, iss, iif, il, e_ifv, e_busv;
      logic [AW-1:0] ia, wa;
      if_req = ti_req; if_burst = ti_burst; if_addr = ti_addr;
      bus_req = tb_req; bus_addr = tb_addr;
      @(negedge clk);
      e_ifv  = pend_v && pend_if;
      e_busv = pend_v && !pend_if;
      check("rnd if_rvalid",  64'(if_rvalid),  64'(e_ifv));
      check("rnd bus_rvalid", 64'(bus_rvalid), 64'(e_busv));
      check("rnd if_rdata",   64'(if_rdata),   e_ifv ? 64'(mem_val(pend_addr)) : 64'd0);
      check("rnd bus_rdata",  64'(bus_rdata),  e_busv ? 64'(mem_val(pend_addr)) : 64'd0);
      check("rnd if_last",    64'(if_last),    64'(e_ifv && pend_last));
      g_if = 1'b0; g_bus = 1'b0; iss = 1'b0; iif = 1'b0; il = 1'b0; ia = last_addr;
      if (burst_q.size() != 0) begin
        ia  = burst_q.pop_front();
        iss = 1'b1;
        iif = 1'b1;
        il  = (burst_q.size() == 0);
      end else if (ti_req || tb_req) begin
        if (ti_req && tb_req) g_if = RR_MODE ? !rr_last_if : 1'b1;
        else                  g_if = ti_req;
        g_bus = !g_if;
        iss = 1'b1;
        rr_last_if = g_if;
        if (g_if) begin
          ia  = ti_addr;
          iif = 1'b1;
          il  = !ti_burst;
          if (ti_burst) begin
            for (int k = 1; k < 4; k++) begin
              wa = ti_addr + 11'(k);
              burst_q.push_back((ti_addr & 11'h7FC) | (wa & 11'h003));
            end
          end
        end else begin
          ia = tb_addr;
        end
      end
      check("rnd if_gnt",   64'(if_gnt),   64'(g_if));
      check("rnd bus_gnt",  64'(bus_gnt),  64'(g_bus));
      check("rnd rom_addr", 64'(rom_addr), 64'(ia));
      pend_v = iss; pend_if = iif; pend_addr = ia; pend_last = il;
      if (iss) last_addr = ia;
      step();
      // Requesters hold until granted, then pick a fresh request.
      if (g_if || !ti_req) begin
        ti_req   = ($urandom_range(0, 2) != 0);
        ti_burst = ($urandom_range(0, 3) == 0);
        ti_addr  = 11'($urandom);
      end
      if (g_bus || !tb_req) begin
        tb_req  = ($urandom_range(0, 2) != 0);
        tb_addr = 11'($urandom);
      end
    end
    if_req = 1'b0; bus_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
